// File: rtl/dmem_responder.sv
// Data-memory responder over a word-wide single-port SRAM: load lane extraction/extension
// and read-modify-write sub-word stores. Optional misalign/window trap: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int          SRAM_AW   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_dmem_addr,
  input  logic [31:0]        i_dmem_wdata,
  input  logic               i_dmem_write,
  input  logic               i_dmem_read,
  input  logic               i_dmem_rdu,
  input  logic               i_dmem_byte,
  input  logic               i_dmem_hwrd,
  output logic [31:0]        o_dmem_rdata,
  output logic               o_dmem_stall,
  output logic               o_dmem_fault,
  output logic               o_sram_en,
  output logic               o_sram_we,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [31:0]        o_sram_wdata,
  input  logic [31:0]        i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

  state_t             state;
  logic [SRAM_AW-1:0] lat_index;
  logic [1:0]         lat_lane;
  logic               lat_byte;
  logic               lat_hwrd;
  logic               lat_rdu;
  logic [31:0]        lat_wdata;

  logic [31:0]        offset;
  logic               in_window;
  logic [SRAM_AW-1:0] req_index;
  logic [1:0]         req_lane;
  logic               is_byte;
  logic               is_hwrd;
  logic               is_word;
  logic               req_valid;
  logic               suppress;
  logic               go;
  logic               fault_c;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic               misaligned;
`endif

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic sz_byte, input logic sz_hwrd,
                                          input logic rdu);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    if (sz_byte)
      return rdu ? {24'h0, b} : {{24{b[7]}}, b};
    else if (sz_hwrd)
      return rdu ? {16'h0, h} : {{16{h[15]}}, h};
    else
      return word;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [1:0] lane, input logic sz_byte);
    logic [31:0] result;
    result = word;
    if (sz_byte)
      result[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      result[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return result;
  endfunction

  // BASE_ADDR is window-aligned, so the offset's low bits equal the address's lane bits.
  always_comb begin
    offset    = i_dmem_addr - BASE_ADDR;
    in_window = (offset[31:SRAM_AW+2] == '0);
    req_index = offset[SRAM_AW+1:2];
    is_byte   = i_dmem_byte;
    is_hwrd   = !i_dmem_byte && i_dmem_hwrd;
    is_word   = !i_dmem_byte && !i_dmem_hwrd;
    req_valid = i_dmem_write || i_dmem_read;
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = (is_hwrd && offset[0]) || (is_word && (offset[1:0] != 2'b00));
    suppress   = !in_window || misaligned;
    req_lane   = offset[1:0];
`else
    suppress   = !in_window;
    req_lane   = is_byte ? offset[1:0] : (is_hwrd ? {offset[1], 1'b0} : 2'b00);
`endif
    go = req_valid && !suppress && (state == IDLE);
  end

  // Outputs are decoded from state, and in IDLE directly from the request, so a load
  // stalls in its request cycle and a word store completes in one cycle.
  always_comb begin
    o_dmem_rdata = 32'h0;
    o_dmem_stall = 1'b0;
    o_sram_en    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = 32'h0;
    fault_c      = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          if (req_valid && suppress) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            fault_c = 1'b1;
`endif
          end else if (req_valid) begin
            o_sram_en   = 1'b1;
            o_sram_addr = req_index;
            if (i_dmem_write && is_word) begin
              o_sram_we    = 1'b1;
              o_sram_wdata = i_dmem_wdata;
            end else begin
              o_dmem_stall = 1'b1;
            end
          end
        end
        RD: begin
          o_sram_addr  = lat_index;
          o_dmem_rdata = extract(i_sram_rdata, lat_lane, lat_byte, lat_hwrd, lat_rdu);
        end
        RMW: begin
          o_sram_en    = 1'b1;
          o_sram_we    = 1'b1;
          o_sram_addr  = lat_index;
          o_sram_wdata = merge(i_sram_rdata, lat_wdata, lat_lane, lat_byte);
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign o_dmem_fault = fault_c;
`else
  assign o_dmem_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      lat_index <= '0;
      lat_lane  <= 2'b00;
      lat_byte  <= 1'b0;
      lat_hwrd  <= 1'b0;
      lat_rdu   <= 1'b0;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            lat_index <= req_index;
            lat_lane  <= req_lane;
            lat_byte  <= is_byte;
            lat_hwrd  <= is_hwrd;
            lat_rdu   <= i_dmem_rdu;
            lat_wdata <= i_dmem_wdata;
            if (!i_dmem_write)
              state <= RD;
            else if (!is_word)
              state <= RMW;
          end
        end
        RD:      state <= IDLE;
        RMW:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed spec scenarios plus randomized
// back-to-back traffic checked against a byte-arithmetic memory model.
module tb_dmem_responder;

  localparam int          AW    = 12;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic          i_clk;
  logic          i_rst;
  logic [31:0]   i_dmem_addr;
  logic [31:0]   i_dmem_wdata;
  logic          i_dmem_write;
  logic          i_dmem_read;
  logic          i_dmem_rdu;
  logic          i_dmem_byte;
  logic          i_dmem_hwrd;
  logic [31:0]   o_dmem_rdata;
  logic          o_dmem_stall;
  logic          o_dmem_fault;
  logic          o_sram_en;
  logic          o_sram_we;
  logic [AW-1:0] o_sram_addr;
  logic [31:0]   o_sram_wdata;
  logic [31:0]   i_sram_rdata;

  logic [31:0] sram_mem [0:WORDS-1];
  logic [31:0] ref_mem  [0:WORDS-1];

  int checks;
  int failures;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dmem_responder #(.SRAM_AW(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata),
    .i_dmem_write(i_dmem_write), .i_dmem_read(i_dmem_read),
    .i_dmem_rdu(i_dmem_rdu), .i_dmem_byte(i_dmem_byte), .i_dmem_hwrd(i_dmem_hwrd),
    .o_dmem_rdata(o_dmem_rdata), .o_dmem_stall(o_dmem_stall), .o_dmem_fault(o_dmem_fault),
    .o_sram_en(o_sram_en), .o_sram_we(o_sram_we), .o_sram_addr(o_sram_addr),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous single-port SRAM: read data appears the cycle after an en && !we access.
  always @(posedge i_clk) begin
    if (o_sram_en) begin
      if (o_sram_we) sram_mem[o_sram_addr] = o_sram_wdata;
      else           i_sram_rdata <= sram_mem[o_sram_addr];
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    sram_mem[idx] = val;
    ref_mem[idx]  = val;
  endtask

  // Reference model: works on byte offsets and masks, updates ref_mem for stores.
  task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wr, input logic rd, input logic rdu,
                              input logic byt, input logic hw,
                              output logic [31:0] e_rdata, output int e_cycles,
                              output logic e_en, output logic e_fault);
    int unsigned off;
    int unsigned size;
    int unsigned sh;
    logic [31:0] word;
    logic [31:0] mask;
    bit inwin;
    bit mis;
    e_rdata = 32'h0; e_cycles = 1; e_en = 1'b0; e_fault = 1'b0;
    if (!(wr || rd)) return;
    size  = byt ? 1 : (hw ? 2 : 4);
    off   = addr - BASE;
    inwin = off < 4 * WORDS;
    mis   = (off % size) != 0;
    if (TRAP && (!inwin || mis)) begin
      e_fault = 1'b1;
      return;
    end
    if (!inwin) return;
    off  = off - (off % size);
    e_en = 1'b1;
    word = ref_mem[off / 4];
    sh   = (off % 4) * 8;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    if (wr) begin
      ref_mem[off / 4] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      e_cycles = (size == 4) ? 1 : 2;
    end else begin
      e_rdata = (word >> sh) & mask;
      if (!rdu && size < 4 && e_rdata[8 * size - 1]) e_rdata = e_rdata | ~mask;
      e_cycles = 2;
    end
  endtask

  // Presents one request at posedge+1 and holds it for the given number of cycles.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wr, input logic rd, input logic rdu,
                            input logic byt, input logic hw, input int cycles,
                            output logic s0, output logic en0, output logic we0,
                            output logic f0, output logic [31:0] r0,
                            output logic s1, output logic [31:0] r1);
    i_dmem_addr = addr; i_dmem_wdata = wdata; i_dmem_write = wr; i_dmem_read = rd;
    i_dmem_rdu = rdu; i_dmem_byte = byt; i_dmem_hwrd = hw;
    #1;
    s0 = o_dmem_stall; en0 = o_sram_en; we0 = o_sram_we; f0 = o_dmem_fault; r0 = o_dmem_rdata;
    s1 = 1'b0; r1 = 32'h0;
    @(posedge i_clk); #1;
    if (cycles == 2) begin
      s1 = o_dmem_stall; r1 = o_dmem_rdata;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic clear_inputs();
    i_dmem_addr = 32'h0; i_dmem_wdata = 32'h0; i_dmem_write = 1'b0; i_dmem_read = 1'b0;
    i_dmem_rdu = 1'b0; i_dmem_byte = 1'b0; i_dmem_hwrd = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    clear_inputs();
    #12;
    checks++;
    if ({o_dmem_stall, o_dmem_fault, o_sram_en, o_sram_we} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {o_dmem_stall, o_dmem_fault, o_sram_en, o_sram_we});
    end
    checks++;
    if ({o_dmem_rdata, o_sram_wdata, o_sram_addr} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: rdata=%h wdata=%h addr=%h expected 0", o_dmem_rdata, o_sram_wdata, o_sram_addr);
    end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if ({o_dmem_stall, o_sram_en, o_dmem_rdata} !== '0) begin
      failures++;
      $display("[TB] FAIL idle_outputs: stall=%b en=%b rdata=%h expected 0", o_dmem_stall, o_sram_en, o_dmem_rdata);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] er, r0, r1; int ec; logic een, ef, s0, en0, we0, f0, s1;
    model_access(BASE + 8, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, er, ec, een, ef);
    run_access(BASE + 8, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if ({s0, en0, we0} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL word_store: stall/en/we=%b expected 011", {s0, en0, we0});
    end
    model_access(BASE + 8, 32'h0, 0, 1, 0, 0, 0, er, ec, een, ef);
    run_access(BASE + 8, 32'h0, 0, 1, 0, 0, 0, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if ({s0, s1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL word_load_stall: got %b expected 10", {s0, s1});
    end
    checks++;
    if (r1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL word_load_data: got %h expected deadbeef", r1);
    end
  endtask

  task automatic test_byte_rmw();
    logic [31:0] er, r0, r1; int ec; logic een, ef, s0, en0, we0, f0, s1;
    poke(1, 32'h1122_3344);
    model_access(BASE + 6, 32'h0000_00AA, 1, 0, 0, 1, 0, er, ec, een, ef);
    run_access(BASE + 6, 32'h0000_00AA, 1, 0, 0, 1, 0, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if ({s0, en0, we0, s1} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL byte_rmw_ctrl: stall/en/we/stall1=%b expected 1100", {s0, en0, we0, s1});
    end
    checks++;
    if (sram_mem[1] !== 32'h11AA_3344) begin
      failures++;
      $display("[TB] FAIL byte_rmw_word: got %h expected 11aa3344", sram_mem[1]);
    end
  endtask

  task automatic test_sign_extension();
    logic [31:0] er, r0, r1; int ec; logic een, ef, s0, en0, we0, f0, s1;
    logic [31:0] addrs [3];
    logic        bytes [3];
    logic        rdus  [3];
    logic [31:0] exps  [3];
    addrs = '{BASE + 9, BASE + 10, BASE + 10};
    bytes = '{1'b1, 1'b1, 1'b0};
    rdus  = '{1'b0, 1'b0, 1'b1};
    exps  = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_80FF};
    poke(2, 32'h80FF_7F01);
    for (int i = 0; i < 3; i++) begin
      model_access(addrs[i], 32'h0, 0, 1, rdus[i], bytes[i], !bytes[i], er, ec, een, ef);
      run_access(addrs[i], 32'h0, 0, 1, rdus[i], bytes[i], !bytes[i], ec, s0, en0, we0, f0, r0, s1, r1);
      checks++;
      if (r1 !== exps[i]) begin
        failures++;
        $display("[TB] FAIL sign_ext_%0d: got %h expected %h", i, r1, exps[i]);
      end
    end
  endtask

  task automatic test_window_miss();
    logic [31:0] er, r0, r1; int ec; logic een, ef, s0, en0, we0, f0, s1;
    model_access(BASE - 4, 32'h0, 0, 1, 0, 0, 0, er, ec, een, ef);
    run_access(BASE - 4, 32'h0, 0, 1, 0, 0, 0, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if ({en0, s0, r0} !== '0) begin
      failures++;
      $display("[TB] FAIL window_miss: en=%b stall=%b rdata=%h expected 0", en0, s0, r0);
    end
    checks++;
    if (f0 !== TRAP) begin
      failures++;
      $display("[TB] FAIL window_miss_fault: got %b expected %b", f0, TRAP);
    end
    clear_inputs(); #1;
    checks++;
    if (o_dmem_fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fault_pulse: got %b expected 0", o_dmem_fault);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] er, r0, r1, v; int ec; logic een, ef, s0, en0, we0, f0, s1;
    v = $urandom;
    poke(0, v);
    model_access(BASE + 1, 32'h0, 0, 1, 1, 0, 1, er, ec, een, ef);
    run_access(BASE + 1, 32'h0, 0, 1, 1, 0, 1, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if (TRAP && {f0, en0, s0} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL misaligned_trap: fault/en/stall=%b expected 100", {f0, en0, s0});
    end else if (!TRAP && {f0, s0, r1} !== {1'b0, 1'b1, 16'h0, v[15:0]}) begin
      failures++;
      $display("[TB] FAIL misaligned_align: fault=%b stall=%b rdata=%h expected 0 1 %h", f0, s0, r1, {16'h0, v[15:0]});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, r0, r1, addr, wd; int ec; logic een, ef, s0, en0, we0, f0, s1;
    logic wr, rd, rdu, byt, hw;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(9, 0))
        0:       addr = BASE - $urandom_range(64, 1);
        1:       addr = BASE + 4 * WORDS + $urandom_range(63, 0);
        default: addr = BASE + $urandom_range(63, 0);
      endcase
      wd = $urandom; wr = 1'($urandom); rd = 1'($urandom); rdu = 1'($urandom);
      byt = 1'($urandom); hw = 1'($urandom);
      model_access(addr, wd, wr, rd, rdu, byt, hw, er, ec, een, ef);
      run_access(addr, wd, wr, rd, rdu, byt, hw, ec, s0, en0, we0, f0, r0, s1, r1);
      checks++;
      if ({s0, en0, we0, f0, r0} !== {ec == 2, een, een && wr && !byt && !hw, ef, 32'h0}) begin
        failures++;
        $display("[TB] FAIL rand_cycle0 n=%0d addr=%h: stall/en/we/fault=%b rdata=%h expected %b rdata=0",
                 n, addr, {s0, en0, we0, f0}, r0, {ec == 2, een, een && wr && !byt && !hw, ef});
      end
      if (ec == 2) begin
        checks++;
        if ({s1, r1} !== {1'b0, wr ? 32'h0 : er}) begin
          failures++;
          $display("[TB] FAIL rand_cycle1 n=%0d addr=%h: stall=%b rdata=%h expected 0 %h",
                   n, addr, s1, r1, wr ? 32'h0 : er);
        end
      end
    end
    clear_inputs();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_in_rmw();
    logic [31:0] er, r0, r1; int ec; logic een, ef, s0, en0, we0, f0, s1;
    poke(1, 32'h1122_3344);
    i_dmem_addr = BASE + 6; i_dmem_wdata = 32'hAA; i_dmem_write = 1'b1; i_dmem_read = 1'b0;
    i_dmem_rdu = 1'b0; i_dmem_byte = 1'b1; i_dmem_hwrd = 1'b0;
    #1;
    checks++;
    if (o_dmem_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rmw_fetch_stall: got %b expected 1", o_dmem_stall);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_sram_en, o_sram_we, o_dmem_stall, o_dmem_rdata, o_sram_addr, o_sram_wdata} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_in_rmw_outputs: en=%b we=%b stall=%b addr=%h wdata=%h expected 0",
               o_sram_en, o_sram_we, o_dmem_stall, o_sram_addr, o_sram_wdata);
    end
    @(posedge i_clk); #1;
    clear_inputs();
    #2;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (sram_mem[1] !== 32'h1122_3344) begin
      failures++;
      $display("[TB] FAIL reset_in_rmw_word: got %h expected 11223344", sram_mem[1]);
    end
    model_access(BASE + 4, 32'h0, 0, 1, 0, 0, 0, er, ec, een, ef);
    run_access(BASE + 4, 32'h0, 0, 1, 0, 0, 0, ec, s0, en0, we0, f0, r0, s1, r1);
    checks++;
    if ({s0, s1, r1} !== {2'b10, 32'h1122_3344}) begin
      failures++;
      $display("[TB] FAIL post_reset_load: stall=%b%b rdata=%h expected 10 11223344", s0, s1, r1);
    end
    clear_inputs();
  endtask

  task automatic test_final_memory();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (sram_mem[i] !== ref_mem[i]) begin
        failures++;
        $display("[TB] FAIL mem_word_%0d: got %h expected %h", i, sram_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sign_extension();
    test_window_miss();
    test_misaligned();
    test_back_to_back();
    test_reset_in_rmw();
    test_final_memory();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
